isr_pipe_ctrl: RTL and testbench

//  Parametrised iterative integer square root with valid/ready handshakes on input and output.

---
 rtl/isr_pipe_ctrl.sv | 121 ++++++++++++
 tb/tb_isr_pipe_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isr_pipe_ctrl.sv
// isr_pipe_ctrl: iterative restoring integer square root with valid/ready
// handshakes. One result bit per cycle, MSB first, using one shared
// WIDTH-bit squarer. Optional remainder output enabled by the macro
// ISR_REMAINDER_EN (remainder = value - result*result, HALF+1 bits).
module isr_pipe_ctrl #(
    parameter int WIDTH = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     value,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH/2-1:0]   result
`ifdef ISR_REMAINDER_EN
    ,
    output logic [WIDTH/2:0]     remainder
`endif
);

    localparam int HALF  = WIDTH / 2;
    localparam int IDX_W = (HALF > 1) ? $clog2(HALF) : 1;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   value_q;
    logic [IDX_W-1:0]   bit_idx;
    logic [HALF-1:0]    trial;
    logic [WIDTH-1:0]   trial_sq;
    logic               trial_ok;

    // Full-width unsigned square; (2^HALF-1)^2 always fits in WIDTH bits.
    function automatic logic [WIDTH-1:0] square(input logic [HALF-1:0] x);
        logic [WIDTH-1:0] xw;
        xw = {{HALF{1'b0}}, x};
        return xw * xw;
    endfunction

    // Trial value for the current bit and its acceptance test.
    always_comb begin
        trial    = result | (HALF'(1) << bit_idx);
        trial_sq = square(trial);
        trial_ok = (trial_sq <= value_q);
    end

    // Control FSM with registered handshake outputs and result accumulator.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            value_q   <= '0;
            bit_idx   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        value_q  <= value;
                        result   <= '0;
                        bit_idx  <= IDX_W'(HALF - 1);
                        in_ready <= 1'b0;
                        state    <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    if (trial_ok) begin
                        result <= trial;
                    end
                    if (bit_idx == '0) begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        bit_idx <= bit_idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    // in_ready stays low here, so no accept can overlap a drain.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef ISR_REMAINDER_EN
    // Running square of the accepted result; only the low HALF+1 bits matter
    // because the final remainder never exceeds 2*result.
    logic [HALF:0] sq_q;

    // Track result^2 and register the remainder on the final COMPUTE cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            sq_q      <= '0;
            remainder <= '0;
        end else if (state == IDLE && in_valid) begin
            sq_q <= '0;
        end else if (state == COMPUTE) begin
            if (trial_ok) begin
                sq_q <= trial_sq[HALF:0];
            end
            if (bit_idx == '0) begin
                remainder <= value_q[HALF:0] - (trial_ok ? trial_sq[HALF:0] : sq_q);
            end
        end
    end
`else
    // No remainder state in this build.
`endif

endmodule

// File: tb/tb_isr_pipe_ctrl.sv
// Scoreboard bench for isr_pipe_ctrl: a 64-bit instance checked through a
// queue and monitor, plus a 16-bit instance exercised with directed vectors.
module tb_isr_pipe_ctrl;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic reset = 1'b1;

    logic        in_valid64  = 1'b0;
    logic        in_ready64;
    logic [63:0] value64     = '0;
    logic        out_valid64;
    logic        out_ready64 = 1'b0;
    logic [31:0] result64;

    logic        in_valid16  = 1'b0;
    logic        in_ready16;
    logic [15:0] value16     = '0;
    logic        out_valid16;
    logic        out_ready16 = 1'b1;
    logic [7:0]  result16;

`ifdef ISR_REMAINDER_EN
    logic [32:0] rem64;
    logic [8:0]  rem16;
`endif

    isr_pipe_ctrl #(.WIDTH(64)) dut64 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid64),
        .in_ready  (in_ready64),
        .value     (value64),
        .out_valid (out_valid64),
        .out_ready (out_ready64),
        .result    (result64)
`ifdef ISR_REMAINDER_EN
        ,
        .remainder (rem64)
`endif
    );

    isr_pipe_ctrl #(.WIDTH(16)) dut16 (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .value     (value16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .result    (result16)
`ifdef ISR_REMAINDER_EN
        ,
        .remainder (rem16)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] v;
        bit          known;
        logic [31:0] r;
        logic [32:0] rem;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    bit rand_mode   = 1'b0;
    bit ready_force = 1'b1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Consumer: drive out_ready just after each rising edge.
    always @(posedge clock) begin
        #1;
        out_ready64 = rand_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Monitor: compare on each output transfer, check hold while stalled.
    logic         held = 1'b0;
    logic [31:0]  held_r;
    logic [32:0]  held_rem;
    logic [127:0] mr, mv;
    always @(negedge clock) begin
        if (reset) begin
            held = 1'b0;
        end else if (out_valid64) begin
            check("done_in_ready", 128'(in_ready64), 128'(0));
            if (held) begin
                check("hold_result", 128'(result64), 128'(held_r));
`ifdef ISR_REMAINDER_EN
                check("hold_rem", 128'(rem64), 128'(held_rem));
`endif
            end
            if (out_ready64) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: actual=%0h required=none", result64);
                end else begin
                    mon_e = sb.pop_front();
                    mr = 128'(result64);
                    mv = 128'(mon_e.v);
                    check("sqrt_low", 128'(mr * mr <= mv), 128'(1));
                    check("sqrt_high", 128'(mv < (mr + 1) * (mr + 1)), 128'(1));
`ifdef ISR_REMAINDER_EN
                    check("rem_prop", 128'(rem64), mv - mr * mr);
`endif
                    if (mon_e.known) begin
                        check("result", 128'(result64), 128'(mon_e.r));
`ifdef ISR_REMAINDER_EN
                        check("remainder", 128'(rem64), 128'(mon_e.rem));
`endif
                    end
                end
                held = 1'b0;
            end else begin
                held     = 1'b1;
                held_r   = result64;
`ifdef ISR_REMAINDER_EN
                held_rem = rem64;
`endif
            end
        end else begin
            held = 1'b0;
        end
    end

    // Issue one radicand to the 64-bit block; returns 1 time unit after accept.
    task automatic send(input logic [63:0] v, input bit known, input logic [31:0] r,
                        input logic [32:0] rem);
        int n = 0;
        @(negedge clock);
        value64    = v;
        in_valid64 = 1'b1;
        while (!in_ready64 && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (n >= 300) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: actual=in_ready low required=accept");
        end else begin
            sb.push_back(exp_t'{v, known, r, rem});
        end
        @(posedge clock);
        #1;
        in_valid64 = 1'b0;
        value64    = {$urandom, $urandom};
    endtask

    // Wait for every queued expectation to be consumed.
    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 5000) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: actual=%0d pending required=0", sb.size());
            sb.delete();
        end
    endtask

    // Count edges from accept until out_valid rises.
    task automatic latency64(input int exp_n);
        int n = 0;
        while (n < 200) begin
            @(posedge clock);
            #1;
            n++;
            if (out_valid64) break;
        end
        check("latency64", 128'(n), 128'(exp_n));
    endtask

    // Directed transaction on the 16-bit block, checked in place.
    task automatic run16(input logic [15:0] v, input logic [7:0] er, input logic [8:0] erem);
        int n = 0;
        @(negedge clock);
        value16    = v;
        in_valid16 = 1'b1;
        check("in_ready16", 128'(in_ready16), 128'(1));
        @(posedge clock);
        #1;
        in_valid16 = 1'b0;
        value16    = 16'h5A5A;
        while (n < 100) begin
            @(posedge clock);
            #1;
            n++;
            if (out_valid16) break;
        end
        check("latency16", 128'(n), 128'(8));
        check("result16", 128'(result16), 128'(er));
`ifdef ISR_REMAINDER_EN
        check("rem16", 128'(rem16), 128'(erem));
`else
        if (erem > 9'd510) $display("note: remainder out of range %0d", erem);
`endif
        @(posedge clock);
        #1;
        check("idle16_in_ready", 128'(in_ready16), 128'(1));
        check("idle16_out_valid", 128'(out_valid16), 128'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", 128'(in_ready64), 128'(1));
        check("rst_out_valid", 128'(out_valid64), 128'(0));
        check("rst_result", 128'(result64), 128'(0));
`ifdef ISR_REMAINDER_EN
        check("rst_rem", 128'(rem64), 128'(0));
`endif
        check("rst_out_valid16", 128'(out_valid16), 128'(0));
        @(negedge clock);
        reset = 1'b0;

        // T1: 100 -> 10, 32-cycle latency
        send(64'd100, 1'b1, 32'd10, 33'd0);
        latency64(32);
        drain();

        // T2: boundaries and perfect squares
        send(64'd0, 1'b1, 32'd0, 33'd0);
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE);
        send(64'h1_0000_0000, 1'b1, 32'd65536, 33'd0);
        send(64'd99, 1'b1, 32'd9, 33'd18);
        drain();

        // T3: backpressure for 10 cycles
        ready_force = 1'b0;
        send(64'd224, 1'b1, 32'd14, 33'd28);
        latency64(32);
        repeat (10) @(negedge clock);
        check("bp_out_valid", 128'(out_valid64), 128'(1));
        check("bp_pending", 128'(sb.size()), 128'(1));
        ready_force = 1'b1;
        drain();
        @(posedge clock);
        #1;
        check("bp_in_ready", 128'(in_ready64), 128'(1));
        check("bp_out_valid_low", 128'(out_valid64), 128'(0));

        // T4: reset in the middle of a computation
        send(64'd300, 1'b1, 32'd17, 33'd11);
        repeat (4) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        sb.delete();
        @(posedge clock);
        #1;
        check("midrst_out_valid", 128'(out_valid64), 128'(0));
        check("midrst_in_ready", 128'(in_ready64), 128'(1));
        check("midrst_result", 128'(result64), 128'(0));
        @(negedge clock);
        reset = 1'b0;
        send(64'd225, 1'b1, 32'd15, 33'd0);
        drain();

        // T5: 16-bit instance
        run16(16'd65535, 8'd255, 9'd510);
        run16(16'd256, 8'd16, 9'd0);

        // T6: random radicands with random backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send({$urandom, $urandom}, 1'b0, 32'd0, 33'd0);
        end
        drain();
        rand_mode = 1'b0;

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
